// File: rtl/pulse_generator_pkg.sv
// Shared types and constants for the pulse generator.
//   state_t        : FSM encoding (IDLE, ACTIVE, GAP)
//   GAP_CNT_WIDTH  : width of the inter-pulse gap counter (MIN_GAP is 1..255)
package pulse_generator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam int GAP_CNT_WIDTH = 8;

endpackage

// File: rtl/rising_edge_detector.sv
// Rising-edge detector for a level input.
//   clock       : rising-edge clock
//   resetn      : synchronous active-low reset, clears the history register
//   signal      : level input
//   rising_edge : high while signal is 1 and was 0 at the previous clock edge
// The history register resets to 0, so a signal that is already high when
// reset releases is reported as an edge on the first edge after release.
module rising_edge_detector (
  input  logic clock,
  input  logic resetn,
  input  logic signal,
  output logic rising_edge
);

  logic signal_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      signal_q <= 1'b0;
    end else begin
      signal_q <= signal;
    end
  end

  assign rising_edge = signal & ~signal_q;

endmodule

// File: rtl/pulse_generator.sv
// Pulse generator: each 0->1 transition of trigger requests one output pulse
// of max(length,1) cycles. Pulses are separated by at least MIN_GAP low
// cycles; requests arriving while a pulse or gap is in progress are queued in
// a saturating pending counter and replayed back-to-back.
//   clock       : rising-edge clock
//   resetn      : synchronous active-low reset
//   trigger     : level request input
//   length      : pulse duration, sampled when a pulse starts
//   pulse       : registered output pulse
//   busy        : registered, high when state != IDLE or pending != 0
//   overflow    : one-cycle flag, a request was dropped (pending saturated)
//   state_dbg   : current FSM state (state_t encoding)
//   pending_dbg : current pending-request count
module pulse_generator
  import pulse_generator_pkg::*;
#(
  parameter int LENGTH_WIDTH  = 8,
  parameter int MIN_GAP       = 1,
  parameter int PENDING_WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     trigger,
  input  logic [LENGTH_WIDTH-1:0]  length,
  output logic                     pulse,
  output logic                     busy,
  output logic                     overflow,
  output logic [1:0]               state_dbg,
  output logic [PENDING_WIDTH-1:0] pending_dbg
);

  localparam logic [GAP_CNT_WIDTH-1:0] GAP_LOAD = GAP_CNT_WIDTH'(MIN_GAP - 1);
  localparam logic [PENDING_WIDTH-1:0] PEND_MAX = {PENDING_WIDTH{1'b1}};

  state_t                   state;
  logic [LENGTH_WIDTH-1:0]  dur_cnt;
  logic [GAP_CNT_WIDTH-1:0] gap_cnt;
  logic [PENDING_WIDTH-1:0] pending;
  logic                     req;
  logic [LENGTH_WIDTH-1:0]  dur_load;

  rising_edge_detector u_edge (
    .clock       (clock),
    .resetn      (resetn),
    .signal      (trigger),
    .rising_edge (req)
  );

  // Counter counts down to 0, so a length of N needs N-1; length 0 acts as 1.
  assign dur_load = (length == '0) ? '0 : length - LENGTH_WIDTH'(1);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= IDLE;
      dur_cnt  <= '0;
      gap_cnt  <= '0;
      pending  <= '0;
      pulse    <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      case (state)
        IDLE: begin
          // pending is always 0 here, so busy simply follows the request.
          if (req) begin
            state   <= ACTIVE;
            dur_cnt <= dur_load;
            pulse   <= 1'b1;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end

        ACTIVE: begin
          busy <= 1'b1;
          if (dur_cnt == '0) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
            pulse   <= 1'b0;
          end else begin
            dur_cnt <= dur_cnt - LENGTH_WIDTH'(1);
          end
          if (req) begin
            if (pending == PEND_MAX) overflow <= 1'b1;
            else                     pending  <= pending + PENDING_WIDTH'(1);
          end
        end

        GAP: begin
          if (gap_cnt == '0) begin
            if ((pending != '0) || req) begin
              state   <= ACTIVE;
              dur_cnt <= dur_load;
              pulse   <= 1'b1;
              busy    <= 1'b1;
              // A queued request is consumed; a same-edge request replaces it
              // (net 0). With nothing queued the new request is consumed.
              if ((pending != '0) && !req) pending <= pending - PENDING_WIDTH'(1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_CNT_WIDTH'(1);
            busy    <= 1'b1;
            if (req) begin
              if (pending == PEND_MAX) overflow <= 1'b1;
              else                     pending  <= pending + PENDING_WIDTH'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          pulse <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg   = state;
  assign pending_dbg = pending;

endmodule

// File: doc/pulse_generator.md
PULSE_GENERATOR -- requirements
Module: pulse_generator

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- LENGTH_WIDTH, 8, width of the length input and duration counter.
- MIN_GAP, 1, low cycles forced between consecutive output pulses; legal values are 1 to 255.
- PENDING_WIDTH, 4, width of the pending-trigger counter (maximum 2^PENDING_WIDTH-1 queued).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clock, input, 1, single clock; all logic on its rising edge.
- resetn, input, 1, synchronous active-low reset.
- trigger, input, 1, level request; each 0->1 transition requests one output pulse.
- length, input, LENGTH_WIDTH, output pulse duration in cycles, sampled when a pulse starts.
- pulse, output, 1, registered output pulse.
- busy, output, 1, high when state is not IDLE or pending is not 0.
- overflow, output, 1, one-cycle flag: a request was dropped because the pending count was saturated.

Function
REQ-003 A request is trigger=1 at a rising clock edge where trigger was 0 at the previous edge; holding trigger high produces exactly one request.
REQ-004 The state machine has three states:
- IDLE: pulse=0.
- ACTIVE: pulse=1.
- GAP: pulse=0.
REQ-005 IDLE transitions to ACTIVE on the edge that samples a request; pulse rises in the following cycle (latency of 1 cycle from the request edge).
REQ-006 When entering ACTIVE, length is sampled; length=0 is treated as 1; pulse stays high for exactly max(length,1) cycles.
REQ-007 ACTIVE transitions to GAP after its final cycle; GAP lasts exactly MIN_GAP cycles.
REQ-008 At the end of GAP:
- if pending>0 or a request is sampled on that edge: go to ACTIVE, with no extra idle cycle;
- otherwise: go to IDLE.
REQ-009 A request sampled in ACTIVE or GAP increments pending, except when it is consumed by the REQ-008 transition on the same edge.
REQ-010 On a REQ-008 transition with pending>0, pending decrements by 1; a simultaneous new request on that edge increments it, so the net change is 0.
REQ-011 When pending is at its maximum, a further request leaves pending unchanged and sets overflow=1 for one cycle; no other state is affected.
REQ-012 A length change while ACTIVE has no effect on the current pulse.
REQ-013 The duration counter never wraps; it loads max(length,1)-1 and counts down to 0.
REQ-014 busy is registered and consistent with state/pending in the same cycle.

Reset
REQ-015 While resetn=0 at a clock edge, the following take effect from the next cycle:
- state=IDLE, pulse=0, busy=0, overflow=0;
- pending=0 and the duration counter=0;
- edge-detect history=0.
REQ-016 Reset asserted mid-pulse or mid-gap aborts immediately and discards all pending requests.
REQ-017 If trigger is high when resetn releases, it counts as a request on the first edge after release.

Structure
REQ-018 Package pulse_generator_pkg holds the state enum type (IDLE, ACTIVE, GAP).
REQ-019 Request detection instantiates the existing rising_edge_detector (ports clock, resetn, signal=trigger, rising_edge); no other sub-module is used.

Verification
REQ-020 Single pulse: LENGTH=5, trigger 0->1 at edge N and held high 20 cycles -> pulse high cycles N+1..N+5 only; busy low from N+1+5+MIN_GAP.
REQ-021 Zero length: length=0, one request -> pulse high exactly 1 cycle.
REQ-022 Queued requests: length=3, MIN_GAP=2, three requests on alternate cycles while ACTIVE -> three 3-cycle pulses, each separated by exactly 2 low cycles; pending returns to 0.
REQ-023 Overflow: PENDING_WIDTH=2, 5 requests during the first pulse -> 3 queued, overflow high 1 cycle on the 5th request, 4 pulses total.
REQ-024 Gap boundary: a request on the last GAP edge with pending=0 -> the next pulse starts with no IDLE cycle.
REQ-025 Reset mid-pulse: resetn low for 1 cycle at cycle 2 of a length=10 pulse with 2 pending -> pulse=0, busy=0 next cycle; no further pulses.
